// File: rtl/engine_result_collector_if.sv
// Engine-side handshake bundle: request lines, one-hot grant, shared result bus.
interface engine_result_collector_if #(
  parameter int NUM_ENGINES = 4,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int ITR_W       = 8
);
  logic [NUM_ENGINES-1:0]       engine_req;
  logic [NUM_ENGINES-1:0]       req_ack;
  logic [X_W+Y_W+ITR_W-1:0]     engine_word;

  // engines drive requests and the word; the collector drives the grant
  modport master (output engine_req, output engine_word, input req_ack);
  modport slave  (input engine_req, input engine_word, output req_ack);
endinterface

// File: rtl/engine_result_collector.sv
// Round-robin collector of engine pixel results into the frame RAM.
// One engine is granted at a time; its {x, y, itr} word is captured one
// cycle after the grant and turned into a single RAM write at x + y*H_RES.
module engine_result_collector #(
  parameter int NUM_ENGINES = 4,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int ITR_W       = 8,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int ADDR_W      = 19,
  parameter int CNT_W       = 19
) (
  input  logic                  clk_iCLK,
  input  logic                  reset_n,
  engine_result_collector_if.slave eng,
  output logic [ADDR_W-1:0]     address_iADDR,
  output logic [ITR_W-1:0]      writedata_iDATA,
  output logic                  write_iWR_en,
  input  logic                  frame_clr,
  output logic                  frame_done,
  output logic [CNT_W-1:0]      pix_count,
  output logic                  oob_err,
  output logic                  busy
);
  localparam int IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [CNT_W-1:0] PIX_MAX = CNT_W'(H_RES * V_RES);

  typedef enum logic [1:0] {IDLE, GRANT, WRITE, RELEASE} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] pick_nxt;
  logic             any_req;

  logic [X_W-1:0]   wx;
  logic [Y_W-1:0]   wy;
  logic [ITR_W-1:0] witr;
  logic             in_range;
  logic [ADDR_W-1:0] lin_addr;

  assign {wx, wy, witr} = eng.engine_word;
  assign in_range = (int'(wx) < H_RES) && (int'(wy) < V_RES);
  // legal coordinates always fit in ADDR_W, so computing at that width is exact
  assign lin_addr = ADDR_W'(wx) + ADDR_W'(wy) * ADDR_W'(H_RES);

  assign busy       = (state != IDLE);
  assign frame_done = (pix_count == PIX_MAX);

  // round-robin pick: first requester at or after ptr; scan runs from the far
  // end backwards so the nearest offset overwrites the others
  always_comb begin
    int               j;
    logic [IDX_W-1:0] jj;
    pick    = ptr;
    any_req = 1'b0;
    j       = 0;
    jj      = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NUM_ENGINES) j = j - NUM_ENGINES;
      jj = IDX_W'(j);
      if (eng.engine_req[jj]) begin
        pick    = jj;
        any_req = 1'b1;
      end
    end
    pick_nxt = (pick == IDX_W'(NUM_ENGINES - 1)) ? '0 : pick + 1'b1;
  end

  // handshake FSM: grant, capture word, single-cycle write, wait for release
  always_ff @(posedge clk_iCLK or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      ptr             <= '0;
      winner          <= '0;
      eng.req_ack     <= '0;
      write_iWR_en    <= 1'b0;
      address_iADDR   <= '0;
      writedata_iDATA <= '0;
      oob_err         <= 1'b0;
    end else begin
      // clear first so a same-cycle out-of-range capture still sets the flag
      if (frame_clr) oob_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            eng.req_ack <= NUM_ENGINES'(1) << pick;
            winner      <= pick;
            ptr         <= pick_nxt;
            state       <= GRANT;
          end
        end
        GRANT: begin
          eng.req_ack <= '0;
          if (in_range) begin
            address_iADDR   <= lin_addr;
            writedata_iDATA <= witr;
            write_iWR_en    <= 1'b1;
          end else begin
            oob_err <= 1'b1;
          end
          state <= WRITE;
        end
        WRITE: begin
          // address/data deliberately held to give the RAM hold margin
          write_iWR_en <= 1'b0;
          state        <= RELEASE;
        end
        RELEASE: begin
          // other requesters wait; a stuck engine stalls here by design
          if (!eng.engine_req[winner]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // pixels written since the last frame clear, saturating at a full frame
  always_ff @(posedge clk_iCLK or negedge reset_n) begin
    if (!reset_n) begin
      pix_count <= '0;
    end else if (frame_clr) begin
      pix_count <= write_iWR_en ? CNT_W'(1) : '0;
    end else if (write_iWR_en && (pix_count != PIX_MAX)) begin
      pix_count <= pix_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_engine_result_collector.sv
// Bench for engine_result_collector: small frame (16x8) so a whole frame is
// cheap; engines are modelled inside the single stimulus process and every
// cycle is checked against a transaction-level reference.
module tb_engine_result_collector;
  localparam int N    = 4;
  localparam int XW   = 6;
  localparam int YW   = 4;
  localparam int IW   = 8;
  localparam int HR   = 16;
  localparam int VR   = 8;
  localparam int AW   = 7;
  localparam int CW   = 8;
  localparam int MAXP = HR * VR;
  localparam int WW   = XW + YW + IW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          frame_clr = 1'b0;
  logic [AW-1:0] addr;
  logic [IW-1:0] wdata;
  logic          wr, done, oob, busy;
  logic [CW-1:0] pix;

  engine_result_collector_if #(.NUM_ENGINES(N), .X_W(XW), .Y_W(YW), .ITR_W(IW)) eif ();

  engine_result_collector #(
    .NUM_ENGINES(N), .X_W(XW), .Y_W(YW), .ITR_W(IW),
    .H_RES(HR), .V_RES(VR), .ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .clk_iCLK        (clk),
    .reset_n         (rst_n),
    .eng             (eif),
    .address_iADDR   (addr),
    .writedata_iDATA (wdata),
    .write_iWR_en    (wr),
    .frame_clr       (frame_clr),
    .frame_done      (done),
    .pix_count       (pix),
    .oob_err         (oob),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // engine behaviour
  logic [WW-1:0] word [N];
  bit            acked [N];
  int            hold [N], cdown [N], gap [N], gcnt [N], drop_cyc [N], grant_cyc [N];
  int            oob_pct;

  // reference: one transaction at a time, timed from its grant cycle
  bit            m_idle, m_wr, m_oob;
  int            m_g, m_w, m_ptr, m_cnt;
  logic [AW-1:0] m_addr;
  logic [IW-1:0] m_data;

  int cyc, checks, errors;
  int glog [$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  function automatic logic [WW-1:0] gen_word();
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    x = XW'($urandom_range(HR - 1, 0));
    y = YW'($urandom_range(VR - 1, 0));
    if ($urandom_range(99, 0) < oob_pct) begin
      if ($urandom_range(1, 0) == 1) x = XW'($urandom_range(63, HR));
      else                           y = YW'($urandom_range(15, VR));
    end
    return {x, y, IW'($urandom)};
  endfunction

  task automatic raise(int i, logic [WW-1:0] w);
    word[i] = w;
    acked[i] = 0;
    eif.engine_req[i] = 1'b1;
  endtask

  task automatic model_reset();
    m_idle = 1; m_wr = 0; m_oob = 0; m_ptr = 0; m_cnt = 0;
    m_addr = '0; m_data = '0; m_g = -100; m_w = 0;
    for (int i = 0; i < N; i++) acked[i] = 0;
  endtask

  // async reset: outputs must clear before any clock edge
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ack", eif.req_ack, 0);
    chk("rst_wr", wr, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", wdata, 0);
    chk("rst_pix", pix, 0);
    chk("rst_done", done, 0);
    chk("rst_oob", oob, 0);
    chk("rst_busy", busy, 0);
    model_reset();
    @(posedge clk);
    cyc++;
    #1 rst_n = 1'b1;
  endtask

  // one clock: advance reference, compare every output, then let engines react
  task automatic tick();
    logic [N-1:0]  req_e;
    logic [WW-1:0] w;
    bit clr_e, wr_b, oob_set;
    int x, y;
    req_e = eif.engine_req; clr_e = frame_clr; wr_b = m_wr; oob_set = 0;
    @(posedge clk);
    cyc++;
    #1;
    frame_clr = 1'b0;
    m_wr = 0;
    if (m_idle) begin
      if (req_e != '0) begin
        m_w = rr_pick(req_e, m_ptr); m_ptr = (m_w + 1) % N; m_g = cyc; m_idle = 0;
      end
    end else if (cyc == m_g + 1) begin
      w = word[m_w];
      x = int'(w[WW-1 -: XW]);
      y = int'(w[IW +: YW]);
      if (x < HR && y < VR) begin
        m_addr = AW'(x + y * HR); m_data = w[IW-1:0]; m_wr = 1;
      end else oob_set = 1;
    end else if (cyc >= m_g + 3 && !req_e[m_w]) m_idle = 1;
    if (clr_e) m_cnt = wr_b ? 1 : 0;
    else if (wr_b && m_cnt < MAXP) m_cnt++;
    if (clr_e) m_oob = 0;
    if (oob_set) m_oob = 1;

    chk("ack", eif.req_ack, (!m_idle && cyc == m_g) ? (32'd1 << m_w) : 32'd0);
    chk("wr", wr, m_wr);
    chk("addr", addr, m_addr);
    chk("data", wdata, m_data);
    chk("pix", pix, m_cnt);
    chk("done", done, m_cnt == MAXP);
    chk("oob", oob, m_oob);
    chk("busy", busy, !m_idle);

    for (int k = 0; k < N; k++)
      if (eif.req_ack[k]) begin glog.push_back(k); grant_cyc[k] = cyc; end

    for (int i = 0; i < N; i++) begin
      if (eif.req_ack[i]) begin
        acked[i] = 1; cdown[i] = hold[i];
      end else if (acked[i]) begin
        cdown[i]--;
        if (cdown[i] <= 0) begin
          eif.engine_req[i] = 1'b0; acked[i] = 0; drop_cyc[i] = cyc; gcnt[i] = gap[i];
        end
      end else if (!eif.engine_req[i] && gap[i] >= 0) begin
        if (gcnt[i] <= 0) begin word[i] = gen_word(); eif.engine_req[i] = 1'b1; end
        else gcnt[i]--;
      end
    end
    eif.engine_word = WW'($urandom);
    for (int i = 0; i < N; i++) if (eif.req_ack[i]) eif.engine_word = word[i];
  endtask

  task automatic wait_ack(int e, int lim);
    int n = 0;
    while (!eif.req_ack[e] && n < lim) begin tick(); n++; end
    chk($sformatf("wait_ack%0d", e), eif.req_ack[e], 1);
  endtask

  task automatic wait_quiet(int lim);
    int n = 0;
    for (int i = 0; i < N; i++) gap[i] = -1;
    while ((busy || eif.engine_req != '0) && n < lim) begin tick(); n++; end
    chk("quiet", {busy, eif.engine_req}, 0);
  endtask

  task automatic random_engines(int pct);
    oob_pct = pct;
    for (int i = 0; i < N; i++) begin
      hold[i] = $urandom_range(3, 1);
      gap[i]  = $urandom_range(4, 1);
      gcnt[i] = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [CW-1:0] pix_b;
    bit wr_seen;
    int n;
    eif.engine_req = '0;
    eif.engine_word = '0;
    oob_pct = 0;
    for (int i = 0; i < N; i++) begin
      hold[i] = 1; gap[i] = -1; gcnt[i] = 0; drop_cyc[i] = 0; grant_cyc[i] = -1000; word[i] = '0;
    end
    model_reset();
    #3;
    do_reset();

    // single request from engine 2
    raise(2, {6'd5, 4'd3, 8'h2A});
    wait_ack(2, 10);
    chk("single_ack", eif.req_ack, 4'b0100);
    tick();
    chk("single_wr", wr, 1);
    chk("single_addr", addr, 5 + 3 * HR);
    chk("single_data", wdata, 8'h2A);
    chk("single_ack_off", eif.req_ack, 0);
    tick();
    chk("single_wr_off", wr, 0);
    chk("single_pix", pix, 1);
    wait_quiet(20);

    // all engines requesting continuously from a fresh pointer
    do_reset();
    glog.delete();
    for (int i = 0; i < N; i++) begin hold[i] = 1; gap[i] = 1; gcnt[i] = 0; raise(i, gen_word()); end
    repeat (26) tick();
    wait_quiet(60);
    for (int k = 0; k < 6; k++)
      chk($sformatf("rr_order%0d", k), (glog.size() > k) ? glog[k] : -1, k % N);

    // out-of-range coordinate: handshake completes, no write
    pix_b = pix;
    wr_seen = 0;
    hold[0] = 1;
    raise(0, {XW'(HR), 4'd0, 8'h11});
    for (int k = 0; k < 12; k++) begin tick(); if (wr) wr_seen = 1; end
    chk("oob_nowr", wr_seen, 0);
    chk("oob_pix", pix, pix_b);
    chk("oob_flag", oob, 1);
    chk("oob_idle", busy, 0);
    frame_clr = 1'b1;
    tick();
    chk("oob_clr", oob, 0);

    // mixed random traffic
    random_engines(20);
    repeat (300) tick();
    wait_quiet(100);

    // full frame, saturation, and clear coinciding with a write
    frame_clr = 1'b1;
    tick();
    random_engines(0);
    n = 0;
    while (m_cnt < MAXP && n < 3000) begin tick(); n++; end
    chk("frame_pix", pix, MAXP);
    chk("frame_done", done, 1);
    repeat (40) tick();
    chk("frame_sat_pix", pix, MAXP);
    chk("frame_sat_done", done, 1);
    n = 0;
    while (!wr && n < 50) begin tick(); n++; end
    chk("clr_wr_seen", wr, 1);
    frame_clr = 1'b1;
    tick();
    chk("clr_pix", pix, 1);
    chk("clr_done", done, 0);
    wait_quiet(100);

    // engine 1 holds its request; engine 3 must wait for the release
    oob_pct = 0;
    hold[1] = 10;
    hold[3] = 1;
    raise(1, gen_word());
    wait_ack(1, 10);
    raise(3, gen_word());
    n = 0;
    while (!eif.req_ack[3] && n < 40) begin tick(); n++; end
    chk("stall_grant3", grant_cyc[3] - grant_cyc[1], 12);
    chk("stall_after_drop", grant_cyc[3] - drop_cyc[1], 2);
    wait_quiet(40);

    // reset during WRITE; pending requests restart with pointer at 0
    do_reset();
    hold[0] = 50;
    raise(0, gen_word());
    wait_ack(0, 10);
    tick();
    chk("mid_in_write", wr, 1);
    hold[3] = 1;
    raise(3, gen_word());
    do_reset();
    hold[0] = 1;
    glog.delete();
    n = 0;
    while (eif.req_ack == '0 && n < 10) begin tick(); n++; end
    chk("mid_regrant", (glog.size() > 0) ? glog[0] : -1, 0);
    wait_quiet(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/engine_result_collector.md
# engine_result_collector

Parametrised result collector between NUM_ENGINES Mandelbrot engines and the dual-port VGA frame RAM. Arbitrates engine result requests round-robin, acknowledges one engine at a time, captures its {x, y, iteration} word from the shared result bus, and issues one RAM write at address x + y*H_RES. Tracks pixels written per frame, flags frame completion, and rejects out-of-range coordinates. Runs in the engine clock domain.

## Interface
- NUM_ENGINES, 4, number of engines / request lines (≥2)
- X_W, 10, x-coordinate width
- Y_W, 9, y-coordinate width
- ITR_W, 8, iteration (pixel data) width
- H_RES, 640, pixels per line
- V_RES, 480, lines per frame
- ADDR_W, 19, RAM address width (must hold H_RES*V_RES-1)
- CNT_W, 19, pixel counter width (must hold H_RES*V_RES)

- clk_iCLK  in  1  engine clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- engine_req  in  NUM_ENGINES  engine i high = result ready; held until handshake completes
- req_ack  out  NUM_ENGINES  one-hot grant; selected engine drives engine_word while high
- engine_word  in  X_W+Y_W+ITR_W  shared result bus {x, y, itr}, x in MSBs
- address_iADDR  out  ADDR_W  RAM write address
- writedata_iDATA  out  ITR_W  RAM write data
- write_iWR_en  out  1  RAM write strobe, one cycle per accepted pixel
- frame_clr  in  1  synchronous clear of pix_count, frame_done, oob_err
- frame_done  out  1  high while pix_count == H_RES*V_RES
- pix_count  out  CNT_W  pixels written since last clear
- oob_err  out  1  sticky: a word with x ≥ H_RES or y ≥ V_RES was received
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, GRANT, WRITE, RELEASE. Reset → IDLE.
- IDLE: if engine_req ≠ 0, choose winner = first requesting index scanning ptr, ptr+1, … wrapping mod NUM_ENGINES; req_ack ← one-hot(winner); latch winner index; ptr ← (winner+1) mod NUM_ENGINES; → GRANT. Otherwise stay; req_ack = 0.
- GRANT: sample engine_word into x/y/itr fields; req_ack ← 0. If x < H_RES and y < V_RES: address_iADDR ← x + y*H_RES (computed at ADDR_W, no truncation for legal coords), writedata_iDATA ← itr, write_iWR_en ← 1. Else write_iWR_en stays 0, oob_err ← 1. → WRITE.
- WRITE: write_iWR_en ← 0; address/data hold their values; → RELEASE.
- RELEASE: stay until engine_req[winner] == 0, then → IDLE. Other engines' requests are ignored here. An engine that never drops req stalls the collector (documented, not recovered).
- pix_count increments on every cycle write_iWR_en is high; saturates at H_RES*V_RES. frame_done = (pix_count == H_RES*V_RES).
- frame_clr: pix_count ← 0, oob_err ← 0. If a write strobe occurs the same cycle, pix_count ← 1 (write is counted); oob_err set in the same cycle as clear → oob_err ← 1.
- Arbitration does not depend on frame_clr; handshakes proceed regardless.

## Timing
- Reset values: req_ack 0, write_iWR_en 0, address_iADDR 0, writedata_iDATA 0, pix_count 0, frame_done 0, oob_err 0, busy 0, ptr 0, state IDLE.
- Reset asserted mid-handshake: all outputs return to reset values immediately (async); engine sees req_ack drop and must re-present its request.
- Edge E0 (IDLE, req seen): req_ack high after E0.
- Edge E1: engine_word sampled (engine has one full cycle after ack); req_ack low, write_iWR_en high, address/data valid after E1.
- Edge E2: write_iWR_en low. Address/data stable from E1 through at least E2 (zero hold margin requirement met).
- Edge E3: → IDLE if winner's req already low. Next grant at E4 earliest: minimum 4 cycles per pixel.
- Round-robin: with all engines continuously requesting, each served once per NUM_ENGINES grants.

## Test plan
- Single request: engine 2 asserts req, word x=5, y=3, itr=0x2A → req_ack=4'b0100 for one cycle after E0; after E1 address_iADDR=1925, writedata_iDATA=0x2A, write_iWR_en high exactly one cycle; pix_count=1.
- Round-robin: all 4 engines request continuously, each drops req 1 cycle after ack → grant order 0,1,2,3,0,1; engine 0 not granted twice in a row.
- Out of range: word x=640, y=0 → no write strobe, pix_count unchanged, oob_err=1 until frame_clr; handshake still completes and returns to IDLE.
- Frame completion: 307200 legal writes → frame_done high after the last strobe, pix_count stays 307200 on further writes; frame_clr same cycle as a write → pix_count=1, frame_done=0.
- Stalled release: engine 1 holds req 10 cycles after ack while engine 3 requests → no grant to engine 3 until engine 1 drops; then engine 3 granted 2 cycles later.
- Reset mid-op: reset_n low during WRITE → write_iWR_en, req_ack, counters 0 immediately; after release, pending request granted normally with ptr=0.
